// File: rtl/reduce_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reduce_sum                                                   |
// | Description : Sums the beats of each valid/last-delimited input burst and  |
// |               presents sum, beat count and wrap flag on a ready/valid port. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reduce_sum #(
  parameter int IN_WIDTH  = 8,
  parameter int SUM_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [SUM_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow,
  input  logic                 out_ready
);

  // One bit wider than the wider operand so the carry out is always visible.
  localparam int c_EXT_W = ((IN_WIDTH > SUM_WIDTH) ? IN_WIDTH : SUM_WIDTH) + 1;

  logic [SUM_WIDTH-1:0] r_acc_sum;
  logic [CNT_WIDTH-1:0] r_acc_cnt;
  logic                 r_acc_ovf;

  logic                 r_out_valid;
  logic [SUM_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;
  logic                 r_out_overflow;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_accept_last;
  logic                 w_out_consumed;
  logic [c_EXT_W-1:0]   w_sum_full;
  logic [CNT_WIDTH:0]   w_cnt_full;
  logic                 w_sum_carry;
  logic                 w_cnt_carry;
  logic [SUM_WIDTH-1:0] w_next_sum;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic                 w_next_ovf;

  assign w_in_ready     = !r_out_valid || out_ready;
  assign w_accept       = in_valid && w_in_ready;
  assign w_accept_last  = w_accept && in_last;
  assign w_out_consumed = r_out_valid && out_ready;

  assign w_sum_full  = c_EXT_W'(r_acc_sum) + c_EXT_W'(in_data);
  assign w_cnt_full  = {1'b0, r_acc_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_sum_carry = |w_sum_full[c_EXT_W-1:SUM_WIDTH];
  assign w_cnt_carry = w_cnt_full[CNT_WIDTH];
  assign w_next_sum  = w_sum_full[SUM_WIDTH-1:0];
  assign w_next_cnt  = w_cnt_full[CNT_WIDTH-1:0];
  assign w_next_ovf  = r_acc_ovf || w_sum_carry || w_cnt_carry;

  // Accumulator returns to zero at each burst end so the next burst starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_sum <= '0;
      r_acc_cnt <= '0;
      r_acc_ovf <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        r_acc_sum <= '0;
        r_acc_cnt <= '0;
        r_acc_ovf <= 1'b0;
      end else begin
        r_acc_sum <= w_next_sum;
        r_acc_cnt <= w_next_cnt;
        r_acc_ovf <= w_next_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else if (w_accept_last) begin
      r_out_valid    <= 1'b1;
      r_out_sum      <= w_next_sum;
      r_out_count    <= w_next_cnt;
      r_out_overflow <= w_next_ovf;
    end else if (w_out_consumed) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: tb/tb_reduce_sum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reduce_sum                                                |
// | Description : Directed table-driven bench for reduce_sum.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reduce_sum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready;
  logic        a_out_valid;
  logic [15:0] a_out_sum;
  logic [15:0] a_out_count;
  logic        a_out_overflow;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_sum;
  logic [1:0]  b_out_count;
  logic        b_out_overflow;

  int total;
  int bad;

  reduce_sum #(.IN_WIDTH(8), .SUM_WIDTH(16), .CNT_WIDTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_sum(a_out_sum),
    .out_count(a_out_count), .out_overflow(a_out_overflow), .out_ready(out_ready)
  );

  // Narrow instance: 8-bit sum and 2-bit count to reach both wrap cases quickly.
  reduce_sum #(.IN_WIDTH(8), .SUM_WIDTH(8), .CNT_WIDTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_overflow(b_out_overflow), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [15:0] e_sum;
    logic [15:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  localparam int NVEC = 20;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic v, input logic [7:0] d, input logic l,
                      input logic ordy, input logic e_rdy, input logic e_ov,
                      input logic [15:0] e_sum, input logic [15:0] e_cnt, input logic e_ovf);
    tbl[i] = '{v, d, l, ordy, e_rdy, e_ov, e_sum, e_cnt, e_ovf};
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // 3,5,7 -> 15/3
    setv(0,  1'b1, 8'd3,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    setv(1,  1'b1, 8'd5,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    setv(2,  1'b1, 8'd7,  1'b1, 1'b1, 1'b1, 1'b1, 16'd15, 16'd3, 1'b0);
    setv(3,  1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    // 2, idle, idle, 6 -> 8/2 (idle cycles carry junk data/last)
    setv(4,  1'b1, 8'd2,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    setv(5,  1'b0, 8'd99, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    setv(6,  1'b0, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    setv(7,  1'b1, 8'd6,  1'b1, 1'b1, 1'b1, 1'b1, 16'd8,  16'd2, 1'b0);
    setv(8,  1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    // back-to-back single-beat bursts
    setv(9,  1'b1, 8'd1,  1'b1, 1'b1, 1'b1, 1'b1, 16'd1,  16'd1, 1'b0);
    setv(10, 1'b1, 8'd2,  1'b1, 1'b1, 1'b1, 1'b1, 16'd2,  16'd1, 1'b0);
    setv(11, 1'b1, 8'd3,  1'b1, 1'b1, 1'b1, 1'b1, 16'd3,  16'd1, 1'b0);
    setv(12, 1'b1, 8'd4,  1'b1, 1'b1, 1'b1, 1'b1, 16'd4,  16'd1, 1'b0);
    setv(13, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);
    // result 10 held for 4 stalled cycles while new beats are offered
    setv(14, 1'b1, 8'd10, 1'b1, 1'b0, 1'b1, 1'b1, 16'd10, 16'd1, 1'b0);
    setv(15, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd1, 1'b0);
    setv(16, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd1, 1'b0);
    setv(17, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd1, 1'b0);
    setv(18, 1'b1, 8'd77, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10, 16'd1, 1'b0);
    setv(19, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0,  16'd0, 1'b0);

    // reset with busy-looking inputs
    rst = 1'b1;
    drive(1'b1, 8'd55, 1'b1, 1'b0);
    repeat (2) cyc();
    chk("reset out_valid", 32'(a_out_valid), 32'd0);
    chk("reset out_sum", 32'(a_out_sum), 32'd0);
    chk("reset out_count", 32'(a_out_count), 32'd0);
    chk("reset out_overflow", 32'(a_out_overflow), 32'd0);
    chk("reset b out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    #1;
    chk("post-reset in_ready", 32'(a_in_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(a_in_ready), 32'(tbl[i].e_rdy));
      cyc();
      chk($sformatf("row%0d out_valid", i), 32'(a_out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("row%0d out_sum", i), 32'(a_out_sum), 32'(tbl[i].e_sum));
        chk($sformatf("row%0d out_count", i), 32'(a_out_count), 32'(tbl[i].e_cnt));
        chk($sformatf("row%0d out_overflow", i), 32'(a_out_overflow), 32'(tbl[i].e_ovf));
      end
    end

    // 9,9 then reset mid-burst, then 4 (last): only 4/1 must appear
    drive(1'b1, 8'd9, 1'b0, 1'b1);
    cyc();
    chk("abort beat1 out_valid", 32'(a_out_valid), 32'd0);
    cyc();
    chk("abort beat2 out_valid", 32'(a_out_valid), 32'd0);
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    cyc();
    chk("abort rst out_valid", 32'(a_out_valid), 32'd0);
    rst = 1'b0;
    drive(1'b1, 8'd4, 1'b1, 1'b1);
    cyc();
    chk("abort new out_valid", 32'(a_out_valid), 32'd1);
    chk("abort new out_sum", 32'(a_out_sum), 32'd4);
    chk("abort new out_count", 32'(a_out_count), 32'd1);
    chk("abort new out_overflow", 32'(a_out_overflow), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    cyc();
    chk("abort drain out_valid", 32'(a_out_valid), 32'd0);

    // sum wrap on the 8-bit instance: 200+100 -> 44, then a clean burst of 1
    drive(1'b1, 8'd200, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 8'd100, 1'b1, 1'b1);
    cyc();
    chk("wrap b out_valid", 32'(b_out_valid), 32'd1);
    chk("wrap b out_sum", 32'(b_out_sum), 32'd44);
    chk("wrap b out_count", 32'(b_out_count), 32'd2);
    chk("wrap b out_overflow", 32'(b_out_overflow), 32'd1);
    chk("wide a out_sum", 32'(a_out_sum), 32'd300);
    chk("wide a out_overflow", 32'(a_out_overflow), 32'd0);
    drive(1'b1, 8'd1, 1'b1, 1'b1);
    cyc();
    chk("after wrap b out_sum", 32'(b_out_sum), 32'd1);
    chk("after wrap b out_count", 32'(b_out_count), 32'd1);
    chk("after wrap b out_overflow", 32'(b_out_overflow), 32'd0);

    // count wrap on the 2-bit counter: 5 beats -> count 1, overflow set
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 8'd0, (k == 4), 1'b1);
      cyc();
    end
    chk("cntwrap b out_valid", 32'(b_out_valid), 32'd1);
    chk("cntwrap b out_count", 32'(b_out_count), 32'd1);
    chk("cntwrap b out_overflow", 32'(b_out_overflow), 32'd1);
    chk("cntwrap a out_count", 32'(a_out_count), 32'd5);
    chk("cntwrap a out_overflow", 32'(a_out_overflow), 32'd0);
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    cyc();
    chk("final out_valid", 32'(a_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reduce_sum.md
REDUCE_SUM -- requirements
Module: reduce_sum

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, meaning width of each incoming stream value.
REQ-002 The block SHALL have parameter SUM_WIDTH, default 16, meaning width of the per-burst sum.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, meaning width of the per-burst beat count.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid  input  1  input beat valid.
REQ-007 The block SHALL have port in_data  input  IN_WIDTH  input beat value, unsigned.
REQ-008 The block SHALL have port in_last  input  1  marks the final beat of a burst.
REQ-009 The block SHALL have port in_ready  output  1  block can accept an input beat.
REQ-010 The block SHALL have port out_valid  output  1  result valid.
REQ-011 The block SHALL have port out_sum  output  SUM_WIDTH  sum of all beats of the completed burst.
REQ-012 The block SHALL have port out_count  output  CNT_WIDTH  number of beats in the completed burst.
REQ-013 The block SHALL have port out_overflow  output  1  sum or count wrapped during the burst.
REQ-014 The block SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-015 An input beat SHALL be accepted on a cycle with in_valid=1 and in_ready=1; an output result SHALL be consumed on a cycle with out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally; it SHALL NOT depend on in_valid or in_last.
REQ-017 The block SHALL hold internal registers acc_sum (SUM_WIDTH), acc_cnt (CNT_WIDTH) and acc_ovf (1), all zero outside a burst.
REQ-018 On an accepted non-last beat: acc_sum <= acc_sum + zero-extended in_data, modulo 2^SUM_WIDTH; acc_cnt <= acc_cnt + 1, modulo 2^CNT_WIDTH; acc_ovf <= acc_ovf, or 1 if either addition carries out.
REQ-019 On an accepted last beat: out_sum, out_count and out_overflow SHALL load the values REQ-018 would produce, including that beat; out_valid <= 1 on the next cycle; acc_sum, acc_cnt and acc_ovf SHALL clear to 0.
REQ-020 Latency from an accepted last beat to out_valid=1 SHALL be exactly 1 cycle.
REQ-021 While out_valid=1 and out_ready=0, out_sum, out_count and out_overflow SHALL remain stable, and no input beat SHALL be accepted.
REQ-022 If the output is consumed and no last beat is accepted in the same cycle, out_valid SHALL fall to 0 on the next cycle.
REQ-023 If the output is consumed and a last beat is accepted in the same cycle, out_valid SHALL stay 1 and the output fields SHALL update to the new burst result.
REQ-024 Back-to-back single-beat bursts with out_ready=1 SHALL sustain one result per cycle.
REQ-025 A burst of N beats SHALL report out_count = N mod 2^CNT_WIDTH; a single-beat burst SHALL report out_count = 1.
REQ-026 Cycles with in_valid=0 inside a burst SHALL leave the accumulator unchanged.
REQ-027 in_data and in_last SHALL be ignored on cycles with no accepted beat.

Reset
REQ-028 While rst=1: out_valid=0, out_sum=0, out_count=0, out_overflow=0, acc_sum=0, acc_cnt=0 and acc_ovf=0 on the next edge.
REQ-029 Reset mid-burst SHALL discard the partial burst; the first beat accepted after reset SHALL start a new burst.
REQ-030 in_ready SHALL be 1 in the first cycle after reset deasserts, since out_valid=0.

Verification
REQ-031 The bench SHALL cover: beats 3,5,7 (last on 7), out_ready=1 -> one cycle later out_valid=1, out_sum=15, out_count=3, out_overflow=0.
REQ-032 The bench SHALL cover: IN_WIDTH=8, SUM_WIDTH=8, beats 200,100 (last) -> out_sum=44, out_count=2, out_overflow=1; next burst 1 (last) -> out_sum=1, out_overflow=0.
REQ-033 The bench SHALL cover: result pending with out_ready=0 for 4 cycles -> in_ready=0 and outputs stable for 4 cycles; out_ready=1 -> in_ready=1 in the same cycle.
REQ-034 The bench SHALL cover: single-beat bursts 1,2,3,4, in_valid=1 and out_ready=1 every cycle -> out_sum 1,2,3,4 on four consecutive cycles with out_valid continuously 1.
REQ-035 The bench SHALL cover: beats 9,9, then rst=1 for 1 cycle, then 4 (last) -> out_sum=4, out_count=1, with no result emitted for the aborted burst.
REQ-036 The bench SHALL cover: beats 2,idle,idle,6 (last), in_valid gapped -> out_sum=8, out_count=2.
